nvme_sc_fifo: RTL

NVME_SC_FIFO -- requirements
Module: nvme_sc_fifo

---
 rtl/nvme_sc_fifo.sv | 116 +++++++++++
 1 files changed

// File: rtl/nvme_sc_fifo.sv
// Single-clock FIFO with registered or show-ahead read, occupancy flags and sticky error flags.
// Pointers carry one extra wrap bit so that full and empty can be told apart without a counter.
module nvme_sc_fifo #(
    parameter int DATA_WIDTH      = 540,
    parameter int DEPTH           = 16,
    parameter int SHOWAHEAD       = 0,
    parameter int ALMOST_FULL_TH  = DEPTH - 2,
    parameter int ALMOST_EMPTY_TH = 2
) (
    input  logic                        clock,
    input  logic                        aclr_n,
    input  logic                        sclr,
    input  logic [DATA_WIDTH-1:0]       data,
    input  logic                        wrreq,
    input  logic                        rdreq,
    output logic [DATA_WIDTH-1:0]       q,
    output logic                        empty,
    output logic                        full,
    output logic                        almost_full,
    output logic                        almost_empty,
    output logic [$clog2(DEPTH):0]      usedw,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] AF_TH  = (AW + 1)'(ALMOST_FULL_TH);
    localparam logic [AW:0] AE_TH  = (AW + 1)'(ALMOST_EMPTY_TH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);
    localparam bit SHOW_AHEAD = (SHOWAHEAD != 0);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic [DATA_WIDTH-1:0] q_q, q_d;

    logic                  full_c, empty_c;
    logic [AW:0]           usedw_c;
    logic                  wr_en, rd_en;
    logic [DATA_WIDTH-1:0] head_c;

    // Status is a pure function of the registered pointers, so every flag moves together with usedw.
    always_comb begin
        empty_c = (wr_ptr_q == rd_ptr_q);
        full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        usedw_c = wr_ptr_q - rd_ptr_q;
        head_c  = mem_q[rd_ptr_q[AW-1:0]];
        wr_en   = wrreq && !full_c && !sclr;
        rd_en   = rdreq && !empty_c && !sclr;
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        q_d         = q_q;
        if (sclr) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (rd_en) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                q_d      = head_c;
            end
            if (wrreq && full_c) begin
                overflow_d = 1'b1;
            end
            if (rdreq && empty_c) begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            q_q         <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            q_q         <= q_d;
        end
    end

    // Storage is deliberately left out of reset and sclr.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data;
        end
    end

    assign q            = SHOW_AHEAD ? head_c : q_q;
    assign empty        = empty_c;
    assign full         = full_c;
    assign usedw        = usedw_c;
    assign almost_full  = (usedw_c >= AF_TH);
    assign almost_empty = (usedw_c < AE_TH);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule
